// File: rtl/hazard_scoreboard.sv
// Hazard, forwarding and flush controller for the 5-stage core.
// Tracks a shadow pipeline of instruction tags (EX, MEM, WB) fed from ID.
module hazard_scoreboard #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter bit          FWD_EN     = 1'b1,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  ex_branch_taken,
  output logic                  stall,
  output logic                  flush_ifid,
  output logic                  flush_idex,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  id_wb_bypass_rs1,
  output logic                  id_wb_bypass_rs2,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count,
  output logic [CNT_W-1:0]      retire_count
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_WB  = 2'b01;

  // Later slots only keep the fields their consumers still look at.
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic                  uses_rs1;
    logic                  uses_rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
  } ex_tag_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
  } mem_tag_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
  } wb_tag_t;

  ex_tag_t  ex_t;
  mem_tag_t mem_t;
  wb_tag_t  wb_t;
  ex_tag_t  id_tag;

  logic ex_hit;
  logic mem_hit;
  logic stall_cond;
  logic bubble;

  // A producer slot matches a register; x0 never matches.
  function automatic logic slot_hit(
    input logic                  valid,
    input logic                  reg_write,
    input logic [REG_ADDR_W-1:0] rd,
    input logic [REG_ADDR_W-1:0] r
  );
    return valid && reg_write && (rd == r) && (r != '0);
  endfunction

  // EX operand select; a load still in MEM has no data to forward yet.
  function automatic logic [1:0] fwd_sel(
    input logic                  uses,
    input logic [REG_ADDR_W-1:0] r,
    input mem_tag_t              m,
    input wb_tag_t               w
  );
    logic [1:0] sel;
    sel = SEL_RF;
    if (FWD_EN && uses) begin
      if (slot_hit(m.valid, m.reg_write, m.rd, r) && !m.mem_read) begin
        sel = SEL_MEM;
      end else if (slot_hit(w.valid, w.reg_write, w.rd, r)) begin
        sel = SEL_WB;
      end
    end
    return sel;
  endfunction

  always_comb begin
    id_tag           = '0;
    id_tag.valid     = 1'b1;
    id_tag.rs1       = id_rs1;
    id_tag.rs2       = id_rs2;
    id_tag.uses_rs1  = id_uses_rs1;
    id_tag.uses_rs2  = id_uses_rs2;
    id_tag.rd        = id_rd;
    id_tag.reg_write = id_reg_write;
    id_tag.mem_read  = id_mem_read;
  end

  // Does the ID instruction read a register produced by EX or MEM.
  always_comb begin
    ex_hit  = 1'b0;
    mem_hit = 1'b0;
    if (id_valid) begin
      ex_hit  = (id_uses_rs1 && slot_hit(ex_t.valid, ex_t.reg_write, ex_t.rd, id_rs1)) ||
                (id_uses_rs2 && slot_hit(ex_t.valid, ex_t.reg_write, ex_t.rd, id_rs2));
      mem_hit = (id_uses_rs1 && slot_hit(mem_t.valid, mem_t.reg_write, mem_t.rd, id_rs1)) ||
                (id_uses_rs2 && slot_hit(mem_t.valid, mem_t.reg_write, mem_t.rd, id_rs2));
    end
  end

  always_comb begin
    stall_cond = 1'b0;
    if (FWD_EN) begin
      stall_cond = ex_t.mem_read && ex_hit;
    end else begin
      stall_cond = ex_hit || mem_hit;
    end
  end

  // A taken branch squashes ID anyway, so it overrides any stall.
  assign stall      = stall_cond && !ex_branch_taken;
  assign flush_ifid = ex_branch_taken;
  assign flush_idex = ex_branch_taken;
  assign bubble     = ex_branch_taken || stall || !id_valid;

  assign fwd_a = fwd_sel(ex_t.valid && ex_t.uses_rs1, ex_t.rs1, mem_t, wb_t);
  assign fwd_b = fwd_sel(ex_t.valid && ex_t.uses_rs2, ex_t.rs2, mem_t, wb_t);

  assign id_wb_bypass_rs1 = id_uses_rs1 && slot_hit(wb_t.valid, wb_t.reg_write, wb_t.rd, id_rs1);
  assign id_wb_bypass_rs2 = id_uses_rs2 && slot_hit(wb_t.valid, wb_t.reg_write, wb_t.rd, id_rs2);

  // Shadow pipeline advance; only the ID->EX step can take a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_t  <= '0;
      mem_t <= '0;
      wb_t  <= '0;
    end else begin
      ex_t            <= bubble ? '0 : id_tag;
      mem_t.valid     <= ex_t.valid;
      mem_t.rd        <= ex_t.rd;
      mem_t.reg_write <= ex_t.reg_write;
      mem_t.mem_read  <= ex_t.mem_read;
      wb_t.valid      <= mem_t.valid;
      wb_t.rd         <= mem_t.rd;
      wb_t.reg_write  <= mem_t.reg_write;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count  <= '0;
      flush_count  <= '0;
      retire_count <= '0;
    end else begin
      if (stall && (stall_count != '1)) begin
        stall_count <= stall_count + CNT_W'(1);
      end
      if (ex_branch_taken && (flush_count != '1)) begin
        flush_count <= flush_count + CNT_W'(1);
      end
      if (wb_t.valid && (retire_count != '1)) begin
        retire_count <= retire_count + CNT_W'(1);
      end
    end
  end

endmodule
